commit_unit: RTL

- In-order retirement stage directly downstream of the reorder buffer.
- Each cycle it inspects the ROB head and retires one ready entry:
  - ALU/load results are written to the architectural register file and their rename tags cleared.
  - Stores are issued to memory through a req/ack handshake.
  - Mispredicted branches trigger a pipeline flush and a PC redirect.
- It produces the ROB dequeue strobe (rd_en).

---
 rtl/commit_unit_pkg.sv | 30 +++
 rtl/commit_unit_if.sv | 43 ++++
 rtl/commit_unit_flush_ctrl.sv | 36 +++
 rtl/commit_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types for the in-order commit stage: ROB head entry, instruction
// type encodings and the retirement FSM states.
package commit_unit_pkg;
  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 4;   // tag 0 means "no entry"
  localparam int REG_W     = 5;

  typedef enum logic [1:0] {
    ITYPE_BRANCH = 2'b00,
    ITYPE_STORE  = 2'b01,
    ITYPE_ALU    = 2'b10,
    ITYPE_LOAD   = 2'b11
  } itype_t;

  typedef struct packed {
    itype_t                 itype;
    logic [XLEN-1:0]        result;        // ALU/load value, store address or branch target
    logic                   branch_result; // 1 = mispredicted
    logic [XLEN-1:0]        store_data;
    logic [REG_W-1:0]       dest_reg;
    logic [ROB_IDX_W-1:0]   ROB_number;
    logic                   ready;
  } ROB_entry_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } commit_state_t;
endpackage

// File: rtl/commit_unit_if.sv
// ROB-head / register-file / store / redirect bundle of the commit stage.
// COMMIT_PERF_CNT_EN adds the commit and mispredict counters.
interface commit_if;
  import commit_unit_pkg::*;

  ROB_entry_t            head;
  logic                  head_ready;
  logic                  ROB_head_store;
  logic                  rob_empty;
  logic                  rd_en;
  logic                  rf_wr_en;
  logic [REG_W-1:0]      rf_wr_addr;
  logic [XLEN-1:0]       rf_wr_data;
  logic [ROB_IDX_W-1:0]  rf_clr_tag;
  logic                  st_req;
  logic [XLEN-1:0]       st_addr;
  logic [XLEN-1:0]       st_data;
  logic                  st_ack;
  logic                  flush;
  logic [XLEN-1:0]       redirect_pc;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0]           commit_cnt;
  logic [31:0]           mispredict_cnt;
`endif

  modport master (
`ifdef COMMIT_PERF_CNT_EN
    input  commit_cnt, mispredict_cnt,
`endif
    output head, head_ready, ROB_head_store, rob_empty, st_ack,
    input  rd_en, rf_wr_en, rf_wr_addr, rf_wr_data, rf_clr_tag,
    input  st_req, st_addr, st_data, flush, redirect_pc
  );

  modport slave (
`ifdef COMMIT_PERF_CNT_EN
    output commit_cnt, mispredict_cnt,
`endif
    input  head, head_ready, ROB_head_store, rob_empty, st_ack,
    output rd_en, rf_wr_en, rf_wr_addr, rf_wr_data, rf_clr_tag,
    output st_req, st_addr, st_data, flush, redirect_pc
  );
endinterface

// File: rtl/commit_unit_flush_ctrl.sv
// Mispredict latch: captures the redirect target and holds flush for
// FLUSH_CYCLES cycles via a down-counter that stops at 0.
module commit_flush_ctrl
  import commit_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mispredict,
  input  logic [XLEN-1:0] target,
  output logic            flush_active,
  output logic            flush_last,
  output logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      pc_q <= '0;
    end else if (mispredict) begin
      cnt  <= CW'(FLUSH_CYCLES);
      pc_q <= target;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
    end
  end

  assign flush_active = (cnt != '0);
  assign flush_last   = (cnt == CW'(1));
  assign redirect_pc  = flush_active ? pc_q : '0;
endmodule

// File: rtl/commit_unit.sv
// In-order commit stage: retires at most one ROB head per cycle, issues
// stores through req/ack and flushes on mispredict. COMMIT_PERF_CNT_EN adds counters.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset,
  commit_if.slave bus
);
  commit_state_t   state_q, state_d;
  logic [XLEN-1:0] st_addr_q, st_data_q;
  logic            eligible, is_store, mispredict;
  logic            flush_active, flush_last;
  logic            rd_en, rf_wr_en, st_req;
  logic [REG_W-1:0]     rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;
  logic [ROB_IDX_W-1:0] rf_clr_tag;

  // reset gates eligibility so nothing is retired while held in reset
  assign eligible = reset && (state_q == RUN) && !bus.rob_empty
                    && bus.head_ready && bus.head.ready;
  assign is_store = bus.ROB_head_store || (bus.head.itype == ITYPE_STORE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    rf_clr_tag = '0;
    st_req     = 1'b0;
    mispredict = 1'b0;
    case (state_q)
      RUN: if (eligible) begin
        if (is_store) begin
          state_d = STORE_WAIT;
        end else if (bus.head.itype == ITYPE_BRANCH) begin
          rd_en = 1'b1;
          if (bus.head.branch_result) begin
            mispredict = 1'b1;
            state_d    = FLUSH;
          end
        end else begin
          rd_en      = 1'b1;
          rf_wr_en   = (bus.head.dest_reg != '0);
          rf_wr_addr = bus.head.dest_reg;
          rf_wr_data = bus.head.result;
          rf_clr_tag = bus.head.ROB_number;
        end
      end
      STORE_WAIT: begin
        st_req = 1'b1;
        if (bus.st_ack) begin
          rd_en   = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: if (flush_last) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // store operands captured on entry so they stay stable for the whole handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_addr_q <= '0;
      st_data_q <= '0;
    end else if (eligible && is_store) begin
      st_addr_q <= bus.head.result;
      st_data_q <= bus.head.store_data;
    end
  end

  commit_flush_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush (
    .clk          (clk),
    .reset        (reset),
    .mispredict   (mispredict),
    .target       (bus.head.result),
    .flush_active (flush_active),
    .flush_last   (flush_last),
    .redirect_pc  (bus.redirect_pc)
  );

  assign bus.rd_en      = rd_en;
  assign bus.rf_wr_en   = rf_wr_en;
  assign bus.rf_wr_addr = rf_wr_addr;
  assign bus.rf_wr_data = rf_wr_data;
  assign bus.rf_clr_tag = rf_clr_tag;
  assign bus.st_req     = st_req;
  assign bus.st_addr    = st_req ? st_addr_q : '0;
  assign bus.st_data    = st_req ? st_data_q : '0;
  assign bus.flush      = flush_active;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] commit_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (rd_en)      commit_cnt_q     <= commit_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign bus.commit_cnt     = commit_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
`endif
endmodule
